register_file: RTL and testbench

- Eight-entry 16-bit register file directly downstream of the instruction controller; consumes its reg_src_sel, reg_dst_sel, reg_in_en, reg_out_en and reg_pc_inc strobes.
- r0 is the program counter. r1 is the link register written by JSR. r6 is the stack pointer used by PUSH/POP. r7 is the ALU temp.
- Drives the shared data bus, the ALU operand lines and the fetch address.

---
 rtl/register_file.sv | 53 +++++
 tb/tb_register_file.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// register_file: eight-entry 16-bit register file (r0=PC, r1=link, r6=SP, r7=ALU temp)
// Ports:
//   clk      system clock, state updates on posedge
//   rst      asynchronous active-low reset
//   in       write data from the shared bus
//   src_sel  source register select, dst_sel destination register select
//   in_en    write reg[dst_sel]; out_en drives bus_out and selects the move path
//   pc_inc   increment r0; sp_inc/sp_dec increment/decrement r6
//   bus_out  reg[src_sel] when out_en else zero
//   src_val  reg[src_sel]; dst_val reg[dst_sel]; pc r0; sp r6
module register_file #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] STACK_TOP = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] in,
   input  logic [2:0]  src_sel,
   input  logic [2:0]  dst_sel,
   input  logic        in_en,
   input  logic        out_en,
   input  logic        pc_inc,
   input  logic        sp_inc,
   input  logic        sp_dec,
   output logic [15:0] bus_out,
   output logic [15:0] src_val,
   output logic [15:0] dst_val,
   output logic [15:0] pc,
   output logic [15:0] sp
);
   logic [15:0] r [8];
   logic [15:0] nxt [8];
   logic [15:0] wdata;
   assign src_val = r[src_sel];
   assign dst_val = r[dst_sel];
   assign bus_out = out_en ? r[src_sel] : 16'h0000;
   assign pc = r[0];
   assign sp = r[6];
   assign wdata = out_en ? r[src_sel] : in;
   // A write to a register overrides its own increment/decrement; a self-move
   // therefore reloads the old value and suppresses the pc/sp update.
   always_comb begin
      for (int i = 0; i < 8; i++) nxt[i] = r[i];
      nxt[0] = r[0] + {15'd0, pc_inc};
      nxt[6] = (sp_inc && !sp_dec) ? r[6] + 16'd1 : (sp_dec && !sp_inc) ? r[6] - 16'd1 : r[6];
      if (in_en) nxt[dst_sel] = wdata;
   end
   always_ff @(posedge clk or negedge rst)
      if (!rst)
         for (int i = 0; i < 8; i++) r[i] <= (i == 0) ? RESET_PC : (i == 6) ? STACK_TOP : 16'h0000;
      else
         for (int i = 0; i < 8; i++) r[i] <= nxt[i];
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: scoreboard bench for register_file against an array reference model
module tb_register_file;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] in = '0;
   logic [2:0]  src_sel = '0, dst_sel = '0;
   logic        in_en = 1'b0, out_en = 1'b0, pc_inc = 1'b0, sp_inc = 1'b0, sp_dec = 1'b0;
   logic [15:0] bus_out, src_val, dst_val, pc, sp;

   register_file dut (
      .clk(clk), .rst(rst), .in(in), .src_sel(src_sel), .dst_sel(dst_sel),
      .in_en(in_en), .out_en(out_en), .pc_inc(pc_inc), .sp_inc(sp_inc), .sp_dec(sp_dec),
      .bus_out(bus_out), .src_val(src_val), .dst_val(dst_val), .pc(pc), .sp(sp)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] bus, sv, dv, pc, sp;
   } exp_t;

   exp_t        q[$];
   logic [15:0] m [8];
   int          total = 0;
   int          bad = 0;

   function automatic void cmp(input string n, input logic [15:0] got, input logic [15:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h t=%0t", n, got, want, $time);
      end
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m[i] = 16'h0000;
      m[0] = 16'h0000;
      m[6] = 16'hFFFF;
   endtask

   // One cycle: apply inputs, push the outputs the model predicts for this
   // cycle, then advance the model at the clock edge.
   task automatic drive(input logic [15:0] i, input logic [2:0] s, input logic [2:0] d,
                        input logic ie, input logic oe, input logic pi, input logic si,
                        input logic sd, input logic rv = 1'b1);
      logic [15:0] w;
      logic [15:0] n [8];
      exp_t e;
      in = i; src_sel = s; dst_sel = d; in_en = ie; out_en = oe;
      pc_inc = pi; sp_inc = si; sp_dec = sd;
      #1;
      rst = rv;
      if (!rv) model_reset();
      e.bus = oe ? m[s] : 16'h0000;
      e.sv = m[s];
      e.dv = m[d];
      e.pc = m[0];
      e.sp = m[6];
      q.push_back(e);
      @(posedge clk);
      if (!rst) model_reset();
      else begin
         w = oe ? m[s] : i;
         for (int k = 0; k < 8; k++) n[k] = m[k];
         if (pi) n[0] = m[0] + 16'd1;
         if (si && !sd) n[6] = m[6] + 16'd1;
         if (sd && !si) n[6] = m[6] - 16'd1;
         if (ie) n[d] = w;
         for (int k = 0; k < 8; k++) m[k] = n[k];
      end
      #1;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() != 0) begin
            e = q.pop_front();
            cmp("bus_out", bus_out, e.bus);
            cmp("src_val", src_val, e.sv);
            cmp("dst_val", dst_val, e.dv);
            cmp("pc", pc, e.pc);
            cmp("sp", sp, e.sp);
         end
      end
   end

   initial begin
      int waited;
      model_reset();
      @(posedge clk);
      #1;
      // write to r0 while in reset must not take effect
      drive(16'hBEEF, 0, 0, 1, 0, 0, 0, 0, 0);
      drive(16'hBEEF, 0, 0, 1, 0, 0, 0, 0, 0);
      cmp("reset_pc", pc, 16'h0000);
      cmp("reset_sp", sp, 16'hFFFF);
      repeat (3) drive(0, 0, 0, 0, 0, 1, 0, 0);
      cmp("pc_after_3_inc", pc, 16'h0003);
      // load and move
      drive(16'h0042, 0, 3, 1, 0, 0, 0, 0);
      drive(16'h9999, 3, 5, 1, 1, 0, 0, 0);
      cmp("move_r5", dst_val, 16'h0042);
      // JSR pattern
      drive(16'h0010, 0, 0, 1, 0, 0, 0, 0);
      drive(0, 0, 1, 1, 1, 0, 0, 0);
      drive(16'h0200, 0, 0, 1, 0, 1, 0, 0);
      cmp("jsr_pc", pc, 16'h0200);
      drive(0, 1, 0, 0, 0, 0, 0, 0);
      cmp("jsr_link", src_val, 16'h0010);
      // stack
      repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("sp_dec2", sp, 16'hFFFD);
      drive(0, 0, 0, 0, 0, 0, 1, 1);
      cmp("sp_both_hold", sp, 16'hFFFD);
      repeat (3) drive(0, 0, 0, 0, 0, 0, 1, 0);
      cmp("sp_wrap_up", sp, 16'h0000);
      drive(0, 0, 0, 0, 0, 0, 0, 1);
      cmp("sp_wrap_down", sp, 16'hFFFF);
      // pc wrap concurrent with another write
      drive(16'hFFFF, 0, 0, 1, 0, 0, 0, 0);
      drive(16'h1234, 0, 4, 1, 0, 1, 0, 0);
      cmp("pc_wrap", pc, 16'h0000);
      drive(0, 4, 0, 0, 0, 0, 0, 0);
      cmp("r4_concurrent", src_val, 16'h1234);
      // self-move on r0 suppresses pc_inc, on r6 suppresses sp_dec
      drive(16'h7777, 0, 0, 1, 1, 1, 0, 0);
      cmp("self_move_pc", pc, 16'h0000);
      drive(16'h7777, 6, 6, 1, 1, 0, 0, 1);
      cmp("self_move_sp", sp, 16'hFFFF);
      // async reset between edges
      drive(16'h5555, 0, 2, 1, 0, 0, 0, 0);
      drive(0, 2, 2, 0, 0, 0, 0, 0, 0);
      cmp("async_r2", dst_val, 16'h0000);
      cmp("async_bus", bus_out, 16'h0000);
      drive(0, 0, 0, 0, 0, 1, 0, 0, 1);
      cmp("post_reset_inc", pc, 16'h0001);
      // randomized traffic
      for (int k = 0; k < 400; k++)
         drive(16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
               1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 63) != 0));
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      waited = 0;
      while (q.size() != 0 && waited < 10) begin
         @(posedge clk);
         waited++;
      end
      if (q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
